aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
- Control FSM that sequences the AES-128 encryption datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey, key expansion) through the initial key addition and NUM_ROUNDS rounds.
- Issues the per-round enables, round index, Rcon and final-round MixColumns bypass.
- Provides a valid/ready handshake toward the producer of plaintext/key and toward the consumer of ciphertext.
- Sits beside the state and key registers in the encryption top level and does not touch data itself.

Parameters:
- NUM_ROUNDS, 10, number of cipher rounds (AES-128). Legal value: 10 only; other values are not supported.
- SBOX_LAT, 0, extra wait cycles per round to cover SubBytes/S-box latency; legal range 0..3.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- start_i  in  1  request valid: plaintext and key are presented on the datapath inputs
- ready_o  out  1  controller can accept a request
- flush_i  in  1  synchronous abort of the current operation
- load_o  out  1  datapath loads state <= plaintext ^ key and key_reg <= key
- state_en_o  out  1  state register and key register capture this round's result
- round_o  out  4  current round index, 0 = initial AddRoundKey, 1..NUM_ROUNDS
- rcon_o  out  8  round constant for key expansion of round_o
- mix_bypass_o  out  1  skip MixColumns (final round)
- busy_o  out  1  an operation is in progress (LOAD/ROUND/DONE)
- done_o  out  1  ciphertext valid on the state register
- out_ready_i  in  1  consumer accepts the ciphertext

Behaviour:
- Reset: rst_ni is asynchronous, active-low; clock is clk_i.
- Reset values: state IDLE, ready_o=1, load_o=0, state_en_o=0, round_o=0, rcon_o=0x00, mix_bypass_o=0, busy_o=0, done_o=0, wait counter 0.
- All outputs are decoded from registered state, round and counter values; there are no combinational input-to-output paths.
- IDLE:
  - ready_o=1.
  - If start_i=1 and flush_i=0, go to LOAD.
- LOAD (1 cycle):
  - load_o=1, round_o=0.
  - Next state is ROUND with round=1 and wait counter=0.
- ROUND:
  - round_o=r, rcon_o=RCON[r], with RCON[1..10] = 01,02,04,08,10,20,40,80,1B,36.
  - mix_bypass_o=1 only when r==NUM_ROUNDS.
  - Each round lasts SBOX_LAT+1 cycles. The counter runs 0..SBOX_LAT.
  - state_en_o=1 only on the cycle where counter==SBOX_LAT.
  - On that cycle: if r<NUM_ROUNDS, then r<=r+1 and counter<=0; otherwise go to DONE.
- DONE:
  - done_o=1 and held stable until out_ready_i=1.
  - On done_o && out_ready_i, go to IDLE on the next cycle.
  - ready_o=0 while in DONE, so no back-to-back overlap.
- Latency (start handshake at cycle 0):
  - load_o is high at cycle 1.
  - Round r is active during cycles 2+(r-1)(SBOX_LAT+1) .. 1+r(SBOX_LAT+1).
  - done_o first rises at cycle 2+NUM_ROUNDS(SBOX_LAT+1); that is cycle 12 for SBOX_LAT=0 and cycle 22 for SBOX_LAT=1.
- flush_i in any non-IDLE state:
  - Go to IDLE next cycle with all enables 0, round_o=0, rcon_o=0.
  - No done_o is produced.
- flush_i in IDLE with start_i=1: flush wins and the request is not accepted.
- start_i while not in IDLE is ignored, because ready_o=0.
- round_o never exceeds NUM_ROUNDS. rcon_o=0x00 outside ROUND.
- Asynchronous reset mid-operation returns to the reset values immediately; no partial done_o.

Test Plan:
1. Reset, SBOX_LAT=0:
   - Hold rst_ni=0 for 3 cycles, then release. ready_o=1 and all other outputs 0.
   - Pulse start_i at cycle 0. Required: load_o at cycle 1; state_en_o high on cycles 2..11; round_o steps 1..10; rcon_o sequence 01,02,04,08,10,20,40,80,1B,36; mix_bypass_o high only at cycle 11; done_o at cycle 12.
   - Hook up the full datapath with the FIPS-197 Appendix C.1 vector (key 000102..0f, plaintext 00112233..ff). The state register must read 69c4e0d86a7b0430d8cdb78070b4c55a when done_o=1.
2. Backpressure: hold out_ready_i=0 for 5 cycles after done_o rises. done_o and the state register must stay stable and ready_o=0. Raise out_ready_i: done_o falls next cycle and ready_o=1.
3. SBOX_LAT=2: start at cycle 0. Each round_o value must be held 3 cycles, with state_en_o only on the 3rd cycle. done_o at cycle 32.
4. Flush at round 5: assert flush_i while round_o=5. Next cycle: IDLE, round_o=0, no done_o ever. A new start then completes normally with correct ciphertext.
5. Collisions:
   - start_i and flush_i together in IDLE: no load_o and ready_o stays 1.
   - start_i pulsed during ROUND: ignored, and the round sequence is unchanged.
6. Reset mid-operation: drop rst_ni at round 7. All outputs immediately return to reset values; after release ready_o=1 and there is no spurious done_o.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
//
// Control FSM for an iterative AES-128 encryption datapath. It sequences the
// initial AddRoundKey (LOAD) followed by NUM_ROUNDS rounds. Each round may be
// stretched by SBOX_LAT wait cycles to cover S-box latency. The controller
// never touches data. It only issues the load/capture strobes, the round
// index, the key-schedule round constant and the final-round MixColumns
// bypass to the state and key registers that sit beside it.
//
// Ports
//   clk_i         clock
//   rst_ni        asynchronous active-low reset
//   start_i       request valid: plaintext and key present on datapath inputs
//   ready_o       controller can accept a request (IDLE only)
//   flush_i       synchronous abort, returns to IDLE without producing done_o
//   load_o        datapath loads state <= plaintext ^ key, key_reg <= key
//   state_en_o    state and key registers capture this round's result
//   round_o       current round index (0 = initial AddRoundKey)
//   rcon_o        round constant for key expansion of round_o
//   mix_bypass_o  skip MixColumns (final round)
//   busy_o        operation in progress (LOAD/ROUND/DONE)
//   done_o        ciphertext valid on the state register
//   out_ready_i   consumer accepts the ciphertext
//
// Every output is decoded from registered state, round and wait-counter
// values, so there are no combinational input-to-output paths.
// NUM_ROUNDS must be 10 and SBOX_LAT must lie in 0..3.
// ---------------------------------------------------------------------------
module aes_round_ctrl #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned SBOX_LAT   = 0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    output logic       ready_o,
    input  logic       flush_i,
    output logic       load_o,
    output logic       state_en_o,
    output logic [3:0] round_o,
    output logic [7:0] rcon_o,
    output logic       mix_bypass_o,
    output logic       busy_o,
    output logic       done_o,
    input  logic       out_ready_i
);

    localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);
    localparam logic [1:0] LatMax    = 2'(SBOX_LAT);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRound,
        StDone
    } state_e;

    state_e     r_state;
    state_e     w_state_d;
    logic [3:0] r_round;
    logic [3:0] w_round_d;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_d;

    // High on the last cycle of a round, when the round result is captured.
    logic       w_round_last;

    // Key-schedule round constants for rounds 1..10; zero elsewhere.
    function automatic logic [7:0] rcon_lut(input logic [3:0] rnd);
        logic [7:0] val;
        case (rnd)
            4'd1:    val = 8'h01;
            4'd2:    val = 8'h02;
            4'd3:    val = 8'h04;
            4'd4:    val = 8'h08;
            4'd5:    val = 8'h10;
            4'd6:    val = 8'h20;
            4'd7:    val = 8'h40;
            4'd8:    val = 8'h80;
            4'd9:    val = 8'h1b;
            4'd10:   val = 8'h36;
            default: val = 8'h00;
        endcase
        return val;
    endfunction

    assign w_round_last = (r_state == StRound) && (r_cnt == LatMax);

    // ------------------------------------------------------------------
    // State, round and wait-counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
            r_round <= 4'd0;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_d;
            r_round <= w_round_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state;
        w_round_d = r_round;
        w_cnt_d   = r_cnt;

        unique case (r_state)
            StIdle: begin
                // Flush wins over a simultaneous start.
                if (start_i && !flush_i) begin
                    w_state_d = StLoad;
                    w_round_d = 4'd0;
                    w_cnt_d   = 2'd0;
                end
            end

            StLoad: begin
                if (flush_i) begin
                    w_state_d = StIdle;
                    w_round_d = 4'd0;
                    w_cnt_d   = 2'd0;
                end else begin
                    w_state_d = StRound;
                    w_round_d = 4'd1;
                    w_cnt_d   = 2'd0;
                end
            end

            StRound: begin
                if (flush_i) begin
                    w_state_d = StIdle;
                    w_round_d = 4'd0;
                    w_cnt_d   = 2'd0;
                end else if (w_round_last) begin
                    w_cnt_d = 2'd0;
                    if (r_round < LastRound) begin
                        w_round_d = r_round + 4'd1;
                    end else begin
                        // Round index is cleared so it never lingers past the
                        // final round.
                        w_state_d = StDone;
                        w_round_d = 4'd0;
                    end
                end else begin
                    w_cnt_d = r_cnt + 2'd1;
                end
            end

            StDone: begin
                // Ciphertext is held until the consumer takes it.
                if (flush_i || out_ready_i) begin
                    w_state_d = StIdle;
                    w_round_d = 4'd0;
                    w_cnt_d   = 2'd0;
                end
            end

            default: begin
                w_state_d = StIdle;
                w_round_d = 4'd0;
                w_cnt_d   = 2'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (registered values only)
    // ------------------------------------------------------------------
    always_comb begin
        ready_o      = 1'b0;
        load_o       = 1'b0;
        state_en_o   = 1'b0;
        round_o      = 4'd0;
        rcon_o       = 8'h00;
        mix_bypass_o = 1'b0;
        busy_o       = 1'b1;
        done_o       = 1'b0;

        unique case (r_state)
            StIdle: begin
                ready_o = 1'b1;
                busy_o  = 1'b0;
            end
            StLoad: begin
                load_o = 1'b1;
            end
            StRound: begin
                round_o      = r_round;
                rcon_o       = rcon_lut(r_round);
                mix_bypass_o = (r_round == LastRound);
                state_en_o   = w_round_last;
            end
            StDone: begin
                done_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_round_ctrl
//
// Directed bench for aes_round_ctrl. Instance u_dut0 (SBOX_LAT=0) drives a
// behavioural AES-128 datapath so the FIPS-197 C.1 ciphertext can be checked.
// Instance u_dut1 (SBOX_LAT=2) checks round stretching timing.
// ---------------------------------------------------------------------------
module tb_aes_round_ctrl;

    localparam logic [127:0] Key = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] Pt  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] Ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    // Instance 0 signals
    logic       start0, flush0, out_ready0;
    logic       ready0, load0, en0, mix0, busy0, done0;
    logic [3:0] round0;
    logic [7:0] rcon0;
    // Instance 1 signals
    logic       start1, flush1, out_ready1;
    logic       ready1, load1, en1, mix1, busy1, done1;
    logic [3:0] round1;
    logic [7:0] rcon1;

    // {ready, load, state_en, round, rcon, mix_bypass, busy, done}
    logic [17:0] obs0, obs1;
    assign obs0 = {ready0, load0, en0, round0, rcon0, mix0, busy0, done0};
    assign obs1 = {ready1, load1, en1, round1, rcon1, mix1, busy1, done1};

    localparam logic [17:0] IdleVec = {1'b1, 17'b0};

    aes_round_ctrl #(.NUM_ROUNDS(10), .SBOX_LAT(0)) u_dut0 (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start0),
        .ready_o     (ready0),
        .flush_i     (flush0),
        .load_o      (load0),
        .state_en_o  (en0),
        .round_o     (round0),
        .rcon_o      (rcon0),
        .mix_bypass_o(mix0),
        .busy_o      (busy0),
        .done_o      (done0),
        .out_ready_i (out_ready0)
    );

    aes_round_ctrl #(.NUM_ROUNDS(10), .SBOX_LAT(2)) u_dut1 (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start1),
        .ready_o     (ready1),
        .flush_i     (flush1),
        .load_o      (load1),
        .state_en_o  (en1),
        .round_o     (round1),
        .rcon_o      (rcon1),
        .mix_bypass_o(mix1),
        .busy_o      (busy1),
        .done_o      (done1),
        .out_ready_i (out_ready1)
    );

    // ------------------------------------------------------------------
    // Behavioural AES-128 datapath for instance 0
    // ------------------------------------------------------------------
    logic [7:0] sbox_tbl [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b);
        return {b[6:0], b[7]};
    endfunction

    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, s;
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            s = inv ^ rotl8(inv) ^ rotl8(rotl8(inv)) ^ rotl8(rotl8(rotl8(inv)))
                ^ rotl8(rotl8(rotl8(rotl8(inv)))) ^ 8'h63;
            sbox_tbl[x] = s;
        end
    end

    function automatic logic [7:0] byte_of(input logic [127:0] v, input int i);
        return v[127-8*i -: 8];
    endfunction

    // SubBytes then ShiftRows (column-major state, byte i at row i%4, col i/4)
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = sbox_tbl[byte_of(s, r + 4*((c + r) % 4))];
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s);
        logic [127:0] o = '0;
        for (int c = 0; c < 4; c++) begin
            logic [7:0] a0, a1, a2, a3;
            a0 = byte_of(s, 4*c);
            a1 = byte_of(s, 4*c+1);
            a2 = byte_of(s, 4*c+2);
            a3 = byte_of(s, 4*c+3);
            o[127-8*(4*c)   -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[127-8*(4*c+1) -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[127-8*(4*c+3) -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = {w3[23:0], w3[31:24]};
        t  = {sbox_tbl[t[31:24]] ^ rc, sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]]};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    logic [127:0] st_q, key_q;
    always_ff @(posedge clk_i) begin
        if (load0) begin
            st_q  <= Pt ^ Key;
            key_q <= Key;
        end else if (en0) begin
            st_q  <= (mix0 ? sub_shift(st_q) : mix_cols(sub_shift(st_q)))
                     ^ key_next(key_q, rcon0);
            key_q <= key_next(key_q, rcon0);
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [7:0] rcon_ref(input int r);
        logic [7:0] t [11];
        t = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        return t[r];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int done_seen;

    initial begin
        rst_ni = 1'b0;
        {start0, flush0, out_ready0} = 3'b000;
        {start1, flush1, out_ready1} = 3'b000;

        // 1. Reset values
        tick();
        check("reset_hold0", 128'(obs0), 128'(IdleVec));
        check("reset_hold1", 128'(obs1), 128'(IdleVec));
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        check("reset_release", 128'(obs0), 128'(IdleVec));

        // Full encryption, SBOX_LAT=0
        start0 = 1'b1;
        tick();                       // cycle 1
        start0 = 1'b0;
        check("load_c1", 128'(obs0), 128'({1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0}));
        for (int r = 1; r <= 10; r++) begin
            tick();                   // cycle r+1
            check($sformatf("round_c%0d", r + 1), 128'(obs0),
                  128'({1'b0, 1'b0, 1'b1, 4'(r), rcon_ref(r), (r == 10), 1'b1, 1'b0}));
        end
        tick();                       // cycle 12
        check("done_c12", 128'(obs0), 128'({1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b1}));
        check("ciphertext", st_q, Ct);

        // 2. Backpressure
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("hold_done%0d", i), 128'({done0, ready0}), 128'(2'b10));
            check($sformatf("hold_state%0d", i), st_q, Ct);
        end
        out_ready0 = 1'b1;
        tick();
        check("release", 128'({done0, ready0}), 128'(2'b01));

        // 5a. start and flush together in IDLE
        start0 = 1'b1;
        flush0 = 1'b1;
        tick();
        start0 = 1'b0;
        flush0 = 1'b0;
        check("start_flush_idle", 128'(obs0), 128'(IdleVec));
        tick();
        check("start_flush_idle2", 128'(obs0), 128'(IdleVec));

        // 4. Flush at round 5
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 5; i++) tick();   // cycle 6
        check("at_round5", 128'(round0), 128'(4'd5));
        flush0 = 1'b1;
        tick();
        flush0 = 1'b0;
        check("flush_idle", 128'(obs0), 128'(IdleVec));
        done_seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done0 === 1'b1) done_seen++;
        end
        check("flush_no_done", 128'(done_seen), 128'(0));

        // Restart with a stray start during ROUND (5b)
        start0 = 1'b1;
        tick();                       // cycle 1
        start0 = 1'b0;
        check("restart_load", 128'(load0), 128'(1'b1));
        for (int cyc = 2; cyc <= 11; cyc++) begin
            start0 = (cyc == 4);
            tick();
            check($sformatf("restart_round_c%0d", cyc), 128'({round0, en0}),
                  128'({4'(cyc - 1), 1'b1}));
        end
        start0 = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 20 && done_seen == 0; i++) begin
            tick();
            if (done0 === 1'b1) done_seen = i + 12;
        end
        check("restart_done_cycle", 128'(done_seen), 128'(12));
        check("restart_ciphertext", st_q, Ct);
        tick();
        check("restart_idle", 128'(obs0), 128'(IdleVec));

        // 6. Asynchronous reset at round 7
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 7; i++) tick();   // cycle 8
        check("at_round7", 128'(round0), 128'(4'd7));
        rst_ni = 1'b0;
        #1;
        check("async_reset", 128'(obs0), 128'(IdleVec));
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        check("post_reset", 128'(obs0), 128'(IdleVec));
        done_seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done0 === 1'b1) done_seen++;
        end
        check("post_reset_no_done", 128'(done_seen), 128'(0));

        // 3. SBOX_LAT=2 timing
        out_ready1 = 1'b0;
        start1 = 1'b1;
        tick();                       // cycle 1
        start1 = 1'b0;
        check("lat2_load", 128'({load1, busy1}), 128'(2'b11));
        for (int r = 1; r <= 10; r++) begin
            for (int k = 0; k < 3; k++) begin
                tick();
                check($sformatf("lat2_r%0d_k%0d", r, k), 128'(obs1),
                      128'({1'b0, 1'b0, (k == 2), 4'(r), rcon_ref(r), (r == 10), 1'b1, 1'b0}));
            end
        end
        tick();                       // cycle 32
        check("lat2_done_c32", 128'({done1, ready1}), 128'(2'b10));
        out_ready1 = 1'b1;
        tick();
        check("lat2_idle", 128'(obs1), 128'(IdleVec));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
